// File: rtl/mdu_scheduler.sv
// Multiply/divide scheduler: owns HI/LO, runs MDU ops over a fixed latency and requests stalls.
// Optional MADD/MADDU/MSUB support is enabled by defining MDU_MADD_EN.
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  localparam logic [7:0] MUL_LAT = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic        busy_q;
  logic [7:0]  cnt_q;
  logic [63:0] pend_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul, is_div, is_mac;
  logic [63:0] prod_s, prod_u, div_res, pend_d;
  logic [7:0]  lat_d;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mac = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB);
`else
    is_mac = 1'b0;
`endif
    lat_d = is_div ? DIV_LAT : MUL_LAT;
  end

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
  end

  // Division results are {HI=remainder, LO=quotient}; zero divisor and the
  // single signed overflow case get fixed architectural answers.
  always_comb begin
    div_res = 64'd0;
    if (B == 32'd0) begin
      div_res = {A, 32'hFFFF_FFFF};
    end else if (op == OP_DIV) begin
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        div_res = {32'd0, 32'h8000_0000};
      end else begin
        div_res = {32'($signed(A) % $signed(B)), 32'($signed(A) / $signed(B))};
      end
    end else begin
      div_res = {A % B, A / B};
    end
  end

  always_comb begin
    pend_d = 64'd0;
    case (op)
      OP_MULT:  pend_d = prod_s;
      OP_MULTU: pend_d = prod_u;
      OP_DIV,
      OP_DIVU:  pend_d = div_res;
`ifdef MDU_MADD_EN
      OP_MADD:  pend_d = {hi_q, lo_q} + prod_s;
      OP_MADDU: pend_d = {hi_q, lo_q} + prod_u;
      OP_MSUB:  pend_d = {hi_q, lo_q} - prod_s;
`endif
      default:  pend_d = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end else if (is_mul || is_div || is_mac) begin
              pend_q  <= pend_d;
              cnt_q   <= lat_d;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // start is ignored here; the hazard unit keeps new MDU ops out of Execute.
          if (cnt_q == 8'd1) begin
            {hi_q, lo_q} <= pend_q;
            cnt_q        <= 8'd0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign stall_md    = d_md_use & (busy_q | start);
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign dbg_state_o = (state_q == RUN);

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed plan cases plus randomized ops checked against
// a cycle-level arithmetic model of HI/LO, busy and stall_md.
module tb_mdu_scheduler;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_md, dbg_state;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic        m_busy;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          edge_no;
  int          m_due;

  always #5 clk = ~clk;

  mdu_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .d_md_use(d_md_use), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_accepted(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd9);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] ps, pu;
    logic [31:0] ma, mb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3, 4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 4'd4) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] != b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      4'd7: return acc + ps;
      4'd8: return acc + pu;
      4'd9: return acc - ps;
      default: return 64'd0;
    endcase
  endfunction

  // Model update for one rising edge, using the inputs that were held across it.
  task automatic model_edge();
    if (!reset) begin
      m_busy = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_busy) begin
      if (edge_no == m_due) begin
        {m_hi, m_lo} = m_pend;
        m_busy = 1'b0;
      end
    end else if (start) begin
      if (op == 4'd5) m_hi = A;
      else if (op == 4'd6) m_lo = A;
      else if (op_accepted(op)) begin
        m_pend = ref_result(op, A, B, {m_hi, m_lo});
        m_due  = edge_no + ((op == 4'd3 || op == 4'd4) ? DIV_CYCLES : MULT_CYCLES);
        m_busy = 1'b1;
      end
    end
    edge_no++;
  endtask

  task automatic cycle(input logic st, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic mu, input logic rst);
    @(negedge clk);
    start = st; op = o; A = a; B = b; d_md_use = mu; reset = rst;
    #1;
    check("stall_md", stall_md, mu & (m_busy | st));
    check("busy", busy, m_busy);
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("no_start_in_run", st & busy, 1'b0);
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mu, output int busy_cycles);
    busy_cycles = 0;
    cycle(1'b1, o, a, b, mu, 1'b1);
    for (int i = 0; i < 300 && m_busy; i++) begin
      cycle(1'b0, 4'd0, $urandom, $urandom, mu, 1'b1);
      busy_cycles++;
    end
    if (m_busy) check("op_timeout", 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic st;
    logic [3:0] o;
    reset = 1'b0; start = 1'b0; op = 4'd0; A = '0; B = '0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 1'b0; m_hi = '0; m_lo = '0; m_pend = '0; edge_no = 0; m_due = 0;
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // MULT / MULTU with stall observed while d_md_use is held
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, nb);
    check("mult_busy_cycles", nb, MULT_CYCLES);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    check("stall_after_mult", stall_md, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
    check("multu_hi", HI, 32'd2);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // divisions and corner cases
    run_op(4'd3, -32'sd7, 32'd2, 1'b1, nb);
    check("div_busy_cycles", nb, DIV_CYCLES);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd0, 1'b0, nb);
    check("divu0_lo", LO, 32'hFFFF_FFFF);
    check("divu0_hi", HI, 32'd7);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // MTHI/MTLO are immediate
    run_op(4'd5, 32'hCAFE_0001, 32'd0, 1'b1, nb);
    run_op(4'd6, 32'h1234_5678, 32'd0, 1'b1, nb);
    check("mtlo_busy_cycles", nb, 0);
    check("mtlo_lo", LO, 32'h1234_5678);
    check("mtlo_hi_kept", HI, 32'hCAFE_0001);

    // reset in the middle of a DIV discards the result
    cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    repeat (15) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rst_no_late_hi", HI, 32'd0);
    check("rst_no_late_lo", LO, 32'd0);

    // MADDU carry into HI, or ignored when the feature is absent
    run_op(4'd5, 32'd0, 32'd0, 1'b0, nb);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, nb);
    run_op(4'd8, 32'd1, 32'd1, 1'b0, nb);
`ifdef MDU_MADD_EN
    check("maddu_busy_cycles", nb, MULT_CYCLES);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    check("maddu_busy_cycles", nb, 0);
    check("maddu_hi", HI, 32'd0);
    check("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      st = m_busy ? 1'b0 : ($urandom_range(0, 2) == 0);
      o  = 4'($urandom_range(0, 15));
      cycle(st, o, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 80) != 0));
    end
    for (int i = 0; i < 20 && m_busy; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multiply/divide scheduler for the five-stage pipeline: accepts HI/LO-class operations issued from the Execute stage, sequences them over a fixed multi-cycle latency, owns the HI/LO registers, and raises a stall request that the hazard controller ORs into its existing Stall term. It sits beside the Execute-stage ALU, taking forwarded operands, and presents HI/LO to the Execute result mux for MFHI/MFLO.

## Interface
- MULT_CYCLES, 5, cycles from MULT/MULTU acceptance to HI/LO update (1..255)
- DIV_CYCLES, 10, cycles from DIV/DIVU acceptance to HI/LO update (1..255)

- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low; low at a rising edge resets the block
- start  input  1  Execute-stage instruction is an MDU operation this cycle
- op  input  4  operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB; others ignored
- A  input  32  rs operand (post-forwarding)
- B  input  32  rt operand (post-forwarding)
- d_md_use  input  1  Decode-stage instruction is mult/div/mthi/mtlo/mfhi/mflo/madd*/msub
- busy  output  1  multi-cycle operation in flight
- stall_md  output  1  stall request to hazard controller
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, RUN. Reset: IDLE, busy=0, HI=0, LO=0, counter=0, pending result discarded.
- Acceptance: start=1 with a valid op while IDLE. start while RUN is ignored (hazard logic must prevent it; the bench asserts it never occurs).
- MTHI/MTLO: HI<=A or LO<=A at the accepting edge; no RUN state entered.
- MULT/MULTU: 64-bit signed/unsigned product of A and B latched into a pending register; counter<=MULT_CYCLES; IDLE->RUN.
- DIV/DIVU: LO=quotient, HI=remainder; signed division truncates toward zero, remainder takes the sign of the dividend. counter<=DIV_CYCLES; IDLE->RUN.
- Divide by zero: LO=32'hFFFFFFFF, HI=A (both signed and unsigned).
- Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- RUN: counter decrements each edge; on the edge where counter==1, {HI,LO}<=pending, counter reaches 0, RUN->IDLE.
- stall_md = d_md_use & (busy | start), combinational. MFHI/MFLO therefore never read stale HI/LO, and a second MDU op never reaches Execute while RUN.
- Invalid op with start=1: no state change.

## Timing
- Acceptance edge k: busy=1 for cycles k+1 .. k+LAT; HI/LO new values visible from cycle k+LAT+1 (written at edge k+LAT); busy=0 in the same cycle.
- MTHI/MTLO: visible the cycle after the accepting edge.
- stall_md has zero latency from start/d_md_use/busy.
- Reset mid-RUN: next edge with reset low returns to IDLE; the in-flight result is never written.
- LAT=1: busy high for one cycle only.

## Configuration
- MDU_MADD_EN defined: ops 7/8/9 accepted with MULT_CYCLES latency; pending = {HI,LO} + signed product (MADD), {HI,LO} + unsigned product (MADDU), {HI,LO} - signed product (MSUB), all 64-bit wrap-around. {HI,LO} is sampled at acceptance.
- Not defined: ops 7/8/9 are treated as invalid (no state change, busy stays 0).

## Test plan
- MULT A=32'hFFFFFFFE (-2), B=3 at edge k -> busy for 5 cycles; from k+6, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. MULTU with the same operands -> HI=2, LO=32'hFFFFFFFA.
- DIV A=-7, B=2 -> after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU A=7, B=0 -> LO=32'hFFFFFFFF, HI=7. DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
- d_md_use=1 held during MULT -> stall_md=1 in cycle k and through cycles k+1..k+5, and 0 at k+6. With d_md_use=0 during the same op -> stall_md=0 throughout.
- MTLO A=32'h12345678 -> LO=32'h12345678 next cycle, busy never asserted; HI unchanged.
- reset low at cycle k+3 of DIV -> busy=0, HI=LO=0 next cycle; no later HI/LO update occurs.
- With MDU_MADD_EN: HI=0, LO=32'hFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0. Without the macro: same stimulus leaves HI/LO unchanged and busy=0.
